// File: rtl/pixel_access_arbiter_if.sv
// pixel_access_arbiter_if
//   Bundles the two requester ports (window-fetch reads, result-writeback
//   writes) and the pixel-controller port of pixel_access_arbiter.
//   Pixel buses are packed 20x8; pixel 0 sits in bits [7:0].
// Modports
//   slave  : the arbiter (takes requests and pc_data_out, drives the rest)
//   master : the environment (requesters and pixel controller)
interface pixel_access_arbiter_if;
  // read requester
  logic             rd_req;
  logic [31:0]      rd_addr;
  logic [4:0]       rd_count;
  logic [19:0][7:0] rd_data;
  logic             rd_done;
  // write requester
  logic             wr_req;
  logic [31:0]      wr_addr;
  logic [4:0]       wr_count;
  logic [19:0][7:0] wr_data;
  logic             wr_done;
  // pixel controller
  logic [31:0]      pc_address_read_offset;
  logic [31:0]      pc_address_write_offset;
  logic [4:0]       pc_num_pix_read;
  logic [4:0]       pc_num_pix_write;
  logic [19:0][7:0] pc_data_in;
  logic [19:0][7:0] pc_data_out;
  // status
  logic             busy;
  logic             count_err;

  modport slave (
    input  rd_req, rd_addr, rd_count, wr_req, wr_addr, wr_count, wr_data, pc_data_out,
    output rd_data, rd_done, wr_done, pc_address_read_offset, pc_address_write_offset,
           pc_num_pix_read, pc_num_pix_write, pc_data_in, busy, count_err
  );

  modport master (
    output rd_req, rd_addr, rd_count, wr_req, wr_addr, wr_count, wr_data, pc_data_out,
    input  rd_data, rd_done, wr_done, pc_address_read_offset, pc_address_write_offset,
           pc_num_pix_read, pc_num_pix_write, pc_data_in, busy, count_err
  );
endinterface

// File: rtl/pixel_access_arbiter.sv
// pixel_access_arbiter
//   Shares the pixel SRAM access path between a read requester and a write
//   requester. Each grant becomes one burst held on the pixel-controller port
//   for ACCESS_CYCLES cycles, followed by a one-cycle done pulse.
// Ports
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : pixel_access_arbiter_if.slave (requests, completions, pc_* port,
//          busy, sticky count_err)
// Parameters
//   ACCESS_CYCLES : burst window length, 1..15
// Configuration macro
//   PIXEL_ARB_WRITE_PRIORITY_EN : when defined, write always wins a
//   simultaneous request; otherwise arbitration is round-robin.
module pixel_access_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  pixel_access_arbiter_if.slave bus
);

  localparam logic [4:0] MAX_PIX  = 5'd20;
  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [19:0][7:0] rd_data_q, rd_data_d;
  logic             rd_done_q, rd_done_d;
  logic             wr_done_q, wr_done_d;
  logic [31:0]      rd_off_q, rd_off_d;
  logic [31:0]      wr_off_q, wr_off_d;
  logic [4:0]       num_rd_q, num_rd_d;
  logic [4:0]       num_wr_q, num_wr_d;
  logic [19:0][7:0] data_in_q, data_in_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
`ifndef PIXEL_ARB_WRITE_PRIORITY_EN
  logic             last_wr_q, last_wr_d;  // 1: last grant went to write
`endif

  logic       rd_over, wr_over;
  logic [4:0] rd_cnt_clamp, wr_cnt_clamp;
  logic       grant_rd, grant_wr;

  assign rd_over      = bus.rd_count > MAX_PIX;
  assign wr_over      = bus.wr_count > MAX_PIX;
  assign rd_cnt_clamp = rd_over ? MAX_PIX : bus.rd_count;
  assign wr_cnt_clamp = wr_over ? MAX_PIX : bus.wr_count;

  // Arbitration decision; only acted upon in IDLE.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (bus.rd_req && bus.wr_req) begin
`ifdef PIXEL_ARB_WRITE_PRIORITY_EN
      grant_wr = 1'b1;
`else
      // the side not granted last wins
      grant_rd = last_wr_q;
      grant_wr = !last_wr_q;
`endif
    end else begin
      grant_rd = bus.rd_req;
      grant_wr = bus.wr_req;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    rd_done_d = 1'b0;
    wr_done_d = 1'b0;
    rd_off_d  = rd_off_q;
    wr_off_d  = wr_off_q;
    num_rd_d  = num_rd_q;
    num_wr_d  = num_wr_q;
    data_in_d = data_in_q;
    busy_d    = busy_q;
    err_d     = err_q;
`ifndef PIXEL_ARB_WRITE_PRIORITY_EN
    last_wr_d = last_wr_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_rd) begin
          state_d  = READ;
          cnt_d    = CNT_INIT;
          rd_off_d = bus.rd_addr;
          num_rd_d = rd_cnt_clamp;
          err_d    = err_q | rd_over;
          busy_d   = 1'b1;
`ifndef PIXEL_ARB_WRITE_PRIORITY_EN
          last_wr_d = 1'b0;
`endif
        end else if (grant_wr) begin
          state_d   = WRITE;
          cnt_d     = CNT_INIT;
          wr_off_d  = bus.wr_addr;
          num_wr_d  = wr_cnt_clamp;
          data_in_d = bus.wr_data;
          err_d     = err_q | wr_over;
          busy_d    = 1'b1;
`ifndef PIXEL_ARB_WRITE_PRIORITY_EN
          last_wr_d = 1'b1;
`endif
        end
      end
      READ: begin
        if (cnt_q == 4'd0) begin
          state_d   = DONE;
          num_rd_d  = 5'd0;
          // zero-count bursts return all-zero data instead of the bus value
          rd_data_d = (num_rd_q == 5'd0) ? '0 : bus.pc_data_out;
          rd_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WRITE: begin
        if (cnt_q == 4'd0) begin
          state_d   = DONE;
          num_wr_d  = 5'd0;
          wr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        // requests are ignored here; the done pulse drops on the way out
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_data_q <= '0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      rd_off_q  <= '0;
      wr_off_q  <= '0;
      num_rd_q  <= '0;
      num_wr_q  <= '0;
      data_in_q <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
`ifndef PIXEL_ARB_WRITE_PRIORITY_EN
      last_wr_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      rd_off_q  <= rd_off_d;
      wr_off_q  <= wr_off_d;
      num_rd_q  <= num_rd_d;
      num_wr_q  <= num_wr_d;
      data_in_q <= data_in_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
`ifndef PIXEL_ARB_WRITE_PRIORITY_EN
      last_wr_q <= last_wr_d;
`endif
    end
  end

  assign bus.rd_data                 = rd_data_q;
  assign bus.rd_done                 = rd_done_q;
  assign bus.wr_done                 = wr_done_q;
  assign bus.pc_address_read_offset  = rd_off_q;
  assign bus.pc_address_write_offset = wr_off_q;
  assign bus.pc_num_pix_read         = num_rd_q;
  assign bus.pc_num_pix_write        = num_wr_q;
  assign bus.pc_data_in              = data_in_q;
  assign bus.busy                    = busy_q;
  assign bus.count_err               = err_q;

endmodule

// File: tb/tb_pixel_access_arbiter.sv
// tb_pixel_access_arbiter
//   Directed and randomized stimulus against a timeline reference model:
//   each grant is remembered by the edge it happened on, and every output is
//   derived from the distance to that edge.
module tb_pixel_access_arbiter;
  localparam int AC = 2;

  logic clk;
  logic rst;

  pixel_access_arbiter_if bus();

  pixel_access_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // reference model state
  int           e_idx  = 0;    // edges seen by the model
  int           g_edge = -1;   // edge of the current/last grant, -1 none
  bit           g_wr;
  bit           m_last_wr;
  logic [4:0]   g_cnt;
  logic [31:0]  exp_rd_off, exp_wr_off;
  logic [159:0] exp_data_in, exp_rd_data;
  bit           exp_err;
  logic [159:0] last_pc_out;

  bit done_log[$];   // 0 = rd_done seen, 1 = wr_done seen
  int rd_done_seen;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  function automatic logic [159:0] rnd160();
    logic [159:0] r;
    for (int i = 0; i < 5; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    g_edge      = -1;
    m_last_wr   = 1'b1;
    exp_rd_off  = '0;
    exp_wr_off  = '0;
    exp_data_in = '0;
    exp_rd_data = '0;
    exp_err     = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.rd_req   = 1'b0;
    bus.wr_req   = 1'b0;
    bus.rd_addr  = '0;
    bus.wr_addr  = '0;
    bus.rd_count = '0;
    bus.wr_count = '0;
    bus.wr_data  = '0;
  endtask

  task automatic check_outputs();
    int p;
    bit act, dn;
    p   = (g_edge >= 0) ? e_idx - g_edge : 1000;
    act = (p <= AC - 1);
    dn  = (p == AC);
    chk("pc_num_pix_read",  160'(bus.pc_num_pix_read),  160'((act && !g_wr) ? g_cnt : 5'd0));
    chk("pc_num_pix_write", 160'(bus.pc_num_pix_write), 160'((act && g_wr) ? g_cnt : 5'd0));
    chk("rd_done",   160'(bus.rd_done),   160'(dn && !g_wr));
    chk("wr_done",   160'(bus.wr_done),   160'(dn && g_wr));
    chk("busy",      160'(bus.busy),      160'(p <= AC));
    chk("count_err", 160'(bus.count_err), 160'(exp_err));
    chk("pc_rd_off", 160'(bus.pc_address_read_offset),  160'(exp_rd_off));
    chk("pc_wr_off", 160'(bus.pc_address_write_offset), 160'(exp_wr_off));
    chk("pc_data_in", bus.pc_data_in, exp_data_in);
    chk("rd_data",    bus.rd_data,    exp_rd_data);
  endtask

  // One clock: fresh pixel-controller stub data, model update on the edge,
  // output check on the falling edge.
  task automatic tick();
    int p;
    bit w;
    bus.pc_data_out = rnd160();
    @(posedge clk);
    e_idx++;
    p = (g_edge >= 0) ? e_idx - g_edge : 1000;
    if (p == AC && !g_wr) begin
      last_pc_out = bus.pc_data_out;
      exp_rd_data = (g_cnt == 5'd0) ? '0 : bus.pc_data_out;
    end
    if (p >= AC + 2 && (bus.rd_req || bus.wr_req)) begin
`ifdef PIXEL_ARB_WRITE_PRIORITY_EN
      w = bus.wr_req;
`else
      w = bus.wr_req && (!bus.rd_req || !m_last_wr);
`endif
      m_last_wr = w;
      g_wr      = w;
      g_edge    = e_idx;
      if (w) begin
        g_cnt       = (bus.wr_count > 20) ? 5'd20 : bus.wr_count;
        exp_wr_off  = bus.wr_addr;
        exp_data_in = bus.wr_data;
        if (bus.wr_count > 20) exp_err = 1'b1;
      end else begin
        g_cnt      = (bus.rd_count > 20) ? 5'd20 : bus.rd_count;
        exp_rd_off = bus.rd_addr;
        if (bus.rd_count > 20) exp_err = 1'b1;
      end
    end
    @(negedge clk);
    if (bus.rd_done === 1'b1) begin done_log.push_back(1'b0); rd_done_seen++; end
    if (bus.wr_done === 1'b1) done_log.push_back(1'b1);
    check_outputs();
  endtask

  initial begin
    int v;
    bit e;
    rst = 1'b1;
    idle_inputs();
    bus.pc_data_out = '0;
    last_pc_out     = '0;
    g_wr            = 1'b0;
    g_cnt           = '0;
    rd_done_seen    = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();                       // reset values
    rst = 1'b0;

    // Simultaneous requests held through three bursts
    done_log.delete();
    bus.rd_req = 1'b1; bus.rd_addr = 32'h40; bus.rd_count = 5'd7;
    bus.wr_req = 1'b1; bus.wr_addr = 32'h80; bus.wr_count = 5'd9;
    bus.wr_data = rnd160();
    repeat (3 * (AC + 2)) tick();
    idle_inputs();
    chk("contest_bursts", 160'(done_log.size()), 160'(3));
    for (int i = 0; i < 3; i++) begin
      v = (i < done_log.size()) ? int'(done_log[i]) : 9;
`ifdef PIXEL_ARB_WRITE_PRIORITY_EN
      e = 1'b1;
`else
      e = (i == 1);
`endif
      chk($sformatf("contest_grant%0d", i), 160'(v), 160'(e));
    end
    repeat (AC + 2) tick();

    // Single read of 20 pixels at 0x100
    bus.rd_req = 1'b1; bus.rd_addr = 32'h100; bus.rd_count = 5'd20;
    tick();
    idle_inputs();
    chk("single_num",  160'(bus.pc_num_pix_read), 160'(20));
    chk("single_addr", 160'(bus.pc_address_read_offset), 160'(32'h100));
    for (int k = 1; k <= AC + 1; k++) begin
      tick();
      chk("single_done", 160'(bus.rd_done), 160'(k == AC));
      if (k == AC) chk("single_rd_data", bus.rd_data, last_pc_out);
    end
    repeat (2) tick();

    // Count overflow on write, then a legal read keeps the sticky flag
    bus.wr_req = 1'b1; bus.wr_addr = 32'h2000; bus.wr_count = 5'd25;
    bus.wr_data = rnd160();
    tick();
    idle_inputs();
    chk("ovf_num",  160'(bus.pc_num_pix_write), 160'(20));
    chk("ovf_err",  160'(bus.count_err), 160'(1));
    repeat (AC + 2) tick();
    bus.rd_req = 1'b1; bus.rd_addr = 32'h300; bus.rd_count = 5'd5;
    tick();
    idle_inputs();
    repeat (AC + 2) tick();
    chk("ovf_err_sticky", 160'(bus.count_err), 160'(1));

    // Zero-count read
    bus.rd_req = 1'b1; bus.rd_addr = 32'h500; bus.rd_count = 5'd0;
    tick();
    idle_inputs();
    for (int k = 1; k <= AC + 1; k++) begin
      tick();
      chk("zero_num",  160'(bus.pc_num_pix_read), 160'(0));
      chk("zero_done", 160'(bus.rd_done), 160'(k == AC));
      if (k == AC) chk("zero_rd_data", bus.rd_data, 160'(0));
    end

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      bus.rd_req   = ($urandom_range(0, 2) != 0);
      bus.wr_req   = ($urandom_range(0, 2) != 0);
      bus.rd_addr  = $urandom;
      bus.wr_addr  = $urandom;
      bus.rd_count = 5'($urandom_range(0, 31));
      bus.wr_count = 5'($urandom_range(0, 31));
      bus.wr_data  = rnd160();
      tick();
    end
    idle_inputs();
    repeat (AC + 3) tick();

    // Held read request: one completion per AC+2 cycles
    rd_done_seen = 0;
    bus.rd_req = 1'b1; bus.rd_addr = 32'h700; bus.rd_count = 5'd3;
    repeat (4 * (AC + 2)) tick();
    idle_inputs();
    chk("held_done_count", 160'(rd_done_seen), 160'(4));
    repeat (AC + 3) tick();

    // Reset in the middle of a read burst
    bus.rd_req = 1'b1; bus.rd_addr = 32'h900; bus.rd_count = 5'd11;
    tick();
    idle_inputs();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();                       // outputs clear immediately
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd_done_seen = 0;
    repeat (AC + 3) tick();
    chk("reset_no_done", 160'(rd_done_seen), 160'(0));
    bus.rd_req = 1'b1; bus.rd_addr = 32'h904; bus.rd_count = 5'd11;
    tick();
    idle_inputs();
    repeat (AC + 2) tick();
    chk("rereq_done", 160'(rd_done_seen), 160'(1));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
